// File: rtl/barrel_normalizer_pkg.sv
// Shared types and sizing helpers for the barrel normalizer slice.
package barrel_normalizer_pkg;

    // Control FSM states: wait for an operand, walk the log stages, hold the result.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Number of log-stages needed to normalize a WIDTH-bit operand.
    function automatic int stages_for(input int width);
        return $clog2(width);
    endfunction

    // Shift-amount width: must hold 0..WIDTH inclusive.
    function automatic int shamt_w_for(input int width);
        return $clog2(width) + 1;
    endfunction

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_STAGES  = stages_for(DEF_WIDTH);
    localparam int DEF_SHAMT_W = DEF_STAGES + 1;

endpackage

// File: rtl/barrel_normalizer_if.sv
// Operand/result handshake bundle for the barrel normalizer.
//
// Handshake rule (both directions): a transfer happens on a rising clk edge
// where valid && ready are both 1. The sender keeps valid and its payload
// stable until that edge; ready may change freely and has no effect while
// valid is 0.
interface barrel_normalizer_if
    import barrel_normalizer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) ();

    localparam int SHAMT_W = shamt_w_for(WIDTH);

    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic [SHAMT_W-1:0] out_shamt;
    logic               out_zero;

    // Normalizer side: consumes operands, produces results.
    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_shamt,
        output out_zero
    );

    // Client side: supplies operands, consumes results.
    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_shamt,
        input  out_zero
    );

endinterface

// File: rtl/barrel_normalizer_norm_stage.sv
// One normalize step: test the top 2^k bits and, if all zero, shift left by 2^k.
// The shift itself is a per-bit 2:1 select between the held and shifted word.
module barrel_normalizer_norm_stage
    import barrel_normalizer_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = stages_for(WIDTH)
) (
    input  logic [WIDTH-1:0]  data,
    input  logic [STAGES-1:0] k,
    output logic              zero_top,
    output logic [WIDTH-1:0]  shifted
);

    logic [STAGES-1:0] top_zero_s;
    logic [WIDTH-1:0]  shift_s [STAGES];
    logic [WIDTH-1:0]  sel_data;

    // Precompute the zero test and the shifted word for every stage size.
    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        assign top_zero_s[s] = ~|data[WIDTH-1 -: (1 << s)];
        assign shift_s[s]    = data << (1 << s);
    end

    // Pick the candidate belonging to the stage currently being applied.
    always_comb begin
        zero_top = 1'b0;
        sel_data = data;
        for (int s = 0; s < STAGES; s++) begin
            if (k == STAGES'(s)) begin
                zero_top = top_zero_s[s];
                sel_data = shift_s[s];
            end
        end
    end

    // Per-bit 2:1 select: take the shifted bit only when the top field was empty.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign shifted[i] = zero_top ? sel_data[i] : data[i];
    end

endmodule

// File: rtl/barrel_normalizer.sv
// Multi-cycle left normalizer: one log-stage per clock, largest stage first.
// Produces the normalized word, the leading-zero count and an all-zero flag.
module barrel_normalizer
    import barrel_normalizer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    barrel_normalizer_if.slave  bus,
    output state_t              dbg_state
);

    localparam int STAGES  = stages_for(WIDTH);
    localparam int SHAMT_W = STAGES + 1;

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   data_q;
    logic [SHAMT_W-1:0] count_q;
    logic [STAGES-1:0]  k_q;
    logic               zero_q;

    logic               accept;
    logic               last_stage;
    logic               st_zero_top;
    logic [WIDTH-1:0]   st_data;
    logic [SHAMT_W-1:0] stage_amt;
    logic [SHAMT_W-1:0] count_next;

    assign accept     = bus.in_valid && (state_q == IDLE);
    assign last_stage = (k_q == '0);
    assign stage_amt  = SHAMT_W'(1) << k_q;
    // Stage sums never exceed WIDTH-1, so this cannot wrap.
    assign count_next = st_zero_top ? (count_q + stage_amt) : count_q;

    barrel_normalizer_norm_stage #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES)
    ) u_stage (
        .data     (data_q),
        .k        (k_q),
        .zero_top (st_zero_top),
        .shifted  (st_data)
    );

    // State register; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: accept in IDLE, walk stages down to k=0, release on result handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)        state_d = SHIFT;
            SHIFT:   if (last_stage)    state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    // Outputs decoded from state; the result fields come straight from registers.
    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
        bus.out_data  = data_q;
        bus.out_shamt = count_q;
        bus.out_zero  = zero_q;
        dbg_state     = state_q;
    end

    // Datapath: load on accept, apply one stage per cycle, fix up the all-zero case.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            count_q <= '0;
            k_q     <= STAGES'(STAGES - 1);
            zero_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        data_q  <= bus.in_data;
                        count_q <= '0;
                        k_q     <= STAGES'(STAGES - 1);
                        zero_q  <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (last_stage) begin
                        k_q <= STAGES'(STAGES - 1);
                        // MSB still clear after the last stage means the operand was zero.
                        if (!st_data[WIDTH-1]) begin
                            data_q  <= '0;
                            count_q <= SHAMT_W'(WIDTH);
                            zero_q  <= 1'b1;
                        end else begin
                            data_q  <= st_data;
                            count_q <= count_next;
                            zero_q  <= 1'b0;
                        end
                    end else begin
                        data_q  <= st_data;
                        count_q <= count_next;
                        k_q     <= k_q - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_barrel_normalizer.sv
// Self-checking bench for barrel_normalizer: directed cases from the
// normalize rules plus randomized operands against a leading-zero model.
module tb_barrel_normalizer;
    import barrel_normalizer_pkg::*;

    localparam int W  = 8;
    localparam int S  = $clog2(W);
    localparam int SW = S + 1;

    logic   clk;
    logic   rst_n;
    state_t dbg_state;
    int     total;
    int     bad;
    int     cyc;
    int     valid_cnt;

    logic [W-1:0]  acc_q[$];
    int            acc_cyc_q[$];
    logic [W-1:0]  res_d_q[$];
    logic [SW-1:0] res_s_q[$];
    logic [W-1:0]  exp_q[$];
    logic [SW-1:0] exp_s_q[$];

    barrel_normalizer_if #(.WIDTH(W)) bus ();

    barrel_normalizer #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    // Record transfers at the falling edge, half a cycle before they take effect.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.in_valid && bus.in_ready) begin
                acc_q.push_back(bus.in_data);
                acc_cyc_q.push_back(cyc);
            end
            if (bus.out_valid) begin
                valid_cnt++;
                if (bus.out_ready) begin
                    res_d_q.push_back(bus.out_data);
                    res_s_q.push_back(bus.out_shamt);
                end
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic void ref_norm(input logic [W-1:0] d, output logic [W-1:0] nd,
                                     output logic [SW-1:0] lz, output logic z);
        int  n;
        bit  found;
        n     = W;
        found = 0;
        for (int i = W - 1; i >= 0; i--) begin
            if (!found && d[i]) begin
                n     = W - 1 - i;
                found = 1;
            end
        end
        z  = !found;
        lz = SW'(n);
        nd = found ? (d << n) : '0;
    endfunction

    // ---------------- driver ----------------
    task automatic run_op(input logic [W-1:0] d, output logic [W-1:0] od,
                          output logic [SW-1:0] os, output logic oz, output int lat);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        lat = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.in_ready) break;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_data  = W'($urandom);
        for (int i = 1; i <= 50; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) begin
                lat = i;
                break;
            end
        end
        od = bus.out_data;
        os = bus.out_shamt;
        oz = bus.out_zero;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        #12;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
        total++; if (bus.out_data !== '0) begin bad++; $display("FAIL reset_out_data got=%h want=00", bus.out_data); end
        total++; if (bus.out_shamt !== '0) begin bad++; $display("FAIL reset_out_shamt got=%0d want=0", bus.out_shamt); end
        total++; if (bus.out_zero !== 1'b0) begin bad++; $display("FAIL reset_out_zero got=%b want=0", bus.out_zero); end
        total++; if (dbg_state !== IDLE) begin bad++; $display("FAIL reset_state got=%0d want=%0d", dbg_state, IDLE); end
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed;
        logic [W-1:0]  vec [5];
        logic [W-1:0]  od, ed;
        logic [SW-1:0] os, es;
        logic          oz, ez;
        int            lat;
        vec[0] = 8'b0001_0110; vec[1] = 8'h80; vec[2] = 8'h01; vec[3] = 8'h00; vec[4] = 8'h7F;
        for (int t = 0; t < 5; t++) begin
            ref_norm(vec[t], ed, es, ez);
            run_op(vec[t], od, os, oz, lat);
            total++; if (lat !== S) begin bad++; $display("FAIL dir_latency in=%h got=%0d want=%0d", vec[t], lat, S); end
            total++; if (od !== ed) begin bad++; $display("FAIL dir_data in=%h got=%h want=%h", vec[t], od, ed); end
            total++; if (os !== es) begin bad++; $display("FAIL dir_shamt in=%h got=%0d want=%0d", vec[t], os, es); end
            total++; if (oz !== ez) begin bad++; $display("FAIL dir_zero in=%h got=%b want=%b", vec[t], oz, ez); end
            total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
                bad++; $display("FAIL dir_release in=%h got valid=%b ready=%b want valid=0 ready=1", vec[t], bus.out_valid, bus.in_ready);
            end
        end
        // Anchor the spec examples with literal expectations as well.
        run_op(8'b0001_0110, od, os, oz, lat);
        total++; if (od !== 8'hB0 || os !== SW'(3)) begin bad++; $display("FAIL lit_16 got=%h/%0d want=b0/3", od, os); end
        run_op(8'h00, od, os, oz, lat);
        total++; if (od !== 8'h00 || os !== SW'(8) || oz !== 1'b1) begin bad++; $display("FAIL lit_00 got=%h/%0d/%b want=00/8/1", od, os, oz); end
    endtask

    task automatic test_random;
        logic [W-1:0]  d, od, ed;
        logic [SW-1:0] os, es;
        logic          oz, ez;
        int            lat;
        for (int t = 0; t < 24; t++) begin
            d = W'($urandom_range(0, 255) >> $urandom_range(0, 8));
            ref_norm(d, ed, es, ez);
            run_op(d, od, os, oz, lat);
            total++; if (lat !== S) begin bad++; $display("FAIL rnd_latency in=%h got=%0d want=%0d", d, lat, S); end
            total++; if (od !== ed || os !== es || oz !== ez) begin
                bad++; $display("FAIL rnd_result in=%h got=%h/%0d/%b want=%h/%0d/%b", d, od, os, oz, ed, es, ez);
            end
        end
    endtask

    task automatic test_backpressure;
        int lat;
        int n_acc;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h0F;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.in_ready) break;
        end
        @(posedge clk);
        #1;
        // Keep offering a different operand; it must be ignored while busy.
        bus.in_data = 8'hAA;
        n_acc = acc_q.size();
        lat = -1;
        for (int i = 1; i <= 50; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) begin
                lat = i;
                break;
            end
        end
        total++; if (lat !== S) begin bad++; $display("FAIL bp_latency got=%0d want=%0d", lat, S); end
        for (int c = 0; c < 5; c++) begin
            total++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hF0 || bus.out_shamt !== SW'(4) ||
                bus.out_zero !== 1'b0 || bus.in_ready !== 1'b0) begin
                bad++; $display("FAIL bp_hold cyc=%0d got v=%b d=%h s=%0d z=%b r=%b want v=1 d=f0 s=4 z=0 r=0",
                                c, bus.out_valid, bus.out_data, bus.out_shamt, bus.out_zero, bus.in_ready);
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            bad++; $display("FAIL bp_release got valid=%b ready=%b want valid=0 ready=1", bus.out_valid, bus.in_ready);
        end
        total++; if (acc_q.size() !== n_acc) begin bad++; $display("FAIL bp_no_accept got=%0d want=%0d", acc_q.size(), n_acc); end
    endtask

    task automatic test_back_to_back;
        logic [W-1:0]  ed;
        logic [SW-1:0] es;
        logic          ez;
        acc_q.delete(); acc_cyc_q.delete(); res_d_q.delete(); res_s_q.delete();
        exp_q.delete(); exp_s_q.delete();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h20;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); #1;
            if (acc_q.size() >= 1) break;
        end
        @(posedge clk);
        #1 bus.in_data = 8'h03;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); #1;
            if (acc_q.size() >= 2) break;
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); #1;
            if (res_d_q.size() >= 2) break;
        end
        repeat (6) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        foreach (acc_q[i]) begin
            ref_norm(acc_q[i], ed, es, ez);
            exp_q.push_back(ed);
            exp_s_q.push_back(es);
        end
        total++; if (acc_q.size() !== 2) begin bad++; $display("FAIL b2b_accepts got=%0d want=2", acc_q.size()); end
        total++; if (res_d_q.size() !== 2) begin bad++; $display("FAIL b2b_results got=%0d want=2", res_d_q.size()); end
        if (acc_q.size() == 2 && res_d_q.size() == 2) begin
            total++; if (acc_q[0] !== 8'h20 || acc_q[1] !== 8'h03) begin
                bad++; $display("FAIL b2b_order got=%h,%h want=20,03", acc_q[0], acc_q[1]);
            end
            total++; if (acc_cyc_q[1] - acc_cyc_q[0] !== S + 2) begin
                bad++; $display("FAIL b2b_gap got=%0d want=%0d", acc_cyc_q[1] - acc_cyc_q[0], S + 2);
            end
            for (int i = 0; i < 2; i++) begin
                total++; if (res_d_q[i] !== exp_q[i] || res_s_q[i] !== exp_s_q[i]) begin
                    bad++; $display("FAIL b2b_result idx=%0d got=%h/%0d want=%h/%0d", i, res_d_q[i], res_s_q[i], exp_q[i], exp_s_q[i]);
                end
            end
            total++; if (res_d_q[0] !== 8'h80 || res_s_q[0] !== SW'(2) || res_d_q[1] !== 8'hC0 || res_s_q[1] !== SW'(6)) begin
                bad++; $display("FAIL b2b_literal got=%h/%0d,%h/%0d want=80/2,c0/6", res_d_q[0], res_s_q[0], res_d_q[1], res_s_q[1]);
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [W-1:0]  od;
        logic [SW-1:0] os;
        logic          oz;
        int            lat;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h04;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.in_ready) break;
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        total++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_data !== '0 ||
            bus.out_shamt !== '0 || bus.out_zero !== 1'b0) begin
            bad++; $display("FAIL rst_mid_outputs got v=%b r=%b d=%h s=%0d z=%b want v=0 r=1 d=00 s=0 z=0",
                            bus.out_valid, bus.in_ready, bus.out_data, bus.out_shamt, bus.out_zero);
        end
        @(negedge clk);
        #2 rst_n = 1'b1;
        valid_cnt = 0;
        repeat (10) @(posedge clk);
        #1;
        total++; if (valid_cnt !== 0) begin bad++; $display("FAIL rst_mid_no_result got=%0d want=0", valid_cnt); end
        run_op(8'h40, od, os, oz, lat);
        total++; if (od !== 8'h80 || os !== SW'(1) || oz !== 1'b0 || lat !== S) begin
            bad++; $display("FAIL rst_mid_next got=%h/%0d/%b lat=%0d want=80/1/0 lat=%0d", od, os, oz, lat, S);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        total     = 0;
        bad       = 0;
        cyc       = 0;
        valid_cnt = 0;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop if something wedges beyond every bounded wait.
    initial begin
        #400000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/barrel_normalizer.md
Name: barrel_normalizer

Overview:
- Multi-cycle left-normalizer, the inverse of the barrel shift path: finds the leading-one position of an operand and shifts it left until the MSB is 1.
- Returns both the normalized word and the shift amount, which is the leading-zero count.
- Feeds the shifter's shift-amount input in normalize/renormalize flows. Uses one log-stage per clock, built from the same 2:1 per-bit select structure as the shifter.
- Valid/ready handshake on both sides; holds one operation at a time.

Parameters:
- WIDTH, 8, operand width in bits; power of two, minimum 4.
- STAGES, $clog2(WIDTH), number of shift stages; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand present.
- in_ready  output  1  block can accept an operand.
- in_data  input  WIDTH  operand to normalize.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts the result.
- out_data  output  WIDTH  normalized operand: MSB=1, or all zero.
- out_shamt  output  STAGES+1  leading-zero count, 0..WIDTH.
- out_zero  output  1  operand was all zero.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_data=0, out_shamt=0, out_zero=0, stage counter=STAGES-1.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at edge N: load data register=in_data, count=0, k=STAGES-1, go to SHIFT.
- SHIFT, one stage per cycle:
  - Stage k tests the top 2^k bits of the data register.
  - If they are all zero: data <<= 2^k (zero fill) and count += 2^k.
  - Otherwise data and count are unchanged.
  - k decrements each cycle. After stage k=0 is applied, go to DONE.
- Completion check (stage k=0 edge):
  - If data MSB is still 0, the operand was zero: count forced to WIDTH, out_zero=1, data=0.
  - Otherwise out_zero=0.
- DONE:
  - out_valid rises exactly STAGES cycles after the accept edge N. For WIDTH=8, out_valid=1 after edge N+3.
  - out_data, out_shamt and out_zero are registered and stable while out_valid=1.
  - On out_valid&&out_ready: out_valid=0 at that edge and go to IDLE.
  - in_ready=1 from the following cycle.
- No overlap: in_ready=0 in SHIFT and DONE. in_data is ignored there, and in_valid held high produces no effect.
- Back-to-back throughput: one operation per STAGES+2 cycles.
- out_ready is ignored while out_valid=0.
- Arithmetic: count is STAGES+1 bits wide and cannot overflow. The sum of stage shifts is at most WIDTH-1 before the zero fix-up.
- Reset mid-operation (any state): the operation is abandoned, all outputs return to their reset values, and no result is emitted.

Decomposition:
- Shared package holds:
  - State enum: IDLE, SHIFT, DONE.
  - Helper function/constant for STAGES.
  - Constant SHAMT_W = STAGES+1.
- One natural sub-module: norm_stage.
  - Combinational.
  - Inputs: data, stage index k.
  - Outputs: all-zero-top flag, shifted data.
  - Implemented as a bank of 2:1 per-bit selects.
- The FSM, counters and registers stay in the top module.

Test Plan:
- in_data=8'b0001_0110, out_ready=1 -> out_valid 3 cycles after accept; out_data=8'b1011_0000, out_shamt=3, out_zero=0.
- in_data=8'h80 -> out_data=8'h80, out_shamt=0. in_data=8'h01 -> out_data=8'h80, out_shamt=7.
- in_data=8'h00 -> out_data=8'h00, out_shamt=8, out_zero=1.
- Backpressure: in_data=8'h0F, out_ready=0 for 5 cycles after out_valid -> out_data=8'hF0, out_shamt=4, all held stable, in_ready=0 throughout; out_ready=1 -> out_valid falls next edge and in_ready returns.
- in_valid held high with 8'h20 then 8'h03 -> second operand accepted only after the first handshake completes. Results in order: (8'h80, 2) then (8'hC0, 6), with no extra accepts.
- rst_n asserted during SHIFT with operand 8'h04 -> all outputs go to reset values immediately (async); no out_valid after release; next operand 8'h40 -> (8'h80, 1).
